// File: rtl/mem_arbiter_if.sv
// Bundles the fetch, data and RAM handshake signals around mem_arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32
);
    logic              iREN;
    logic [ADDR_W-1:0] iaddr;
    logic              ihit;
    logic [ADDR_W-1:0] iload;
    logic              dREN;
    logic              dWEN;
    logic              datomic;
    logic [ADDR_W-1:0] daddr;
    logic [ADDR_W-1:0] dstore;
    logic              dhit;
    logic [ADDR_W-1:0] dload;
    logic              ramREN;
    logic              ramWEN;
    logic [ADDR_W-1:0] ramaddr;
    logic [ADDR_W-1:0] ramstore;
    logic [ADDR_W-1:0] ramload;
    logic              ram_ready;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, datomic, daddr, dstore, ramload, ram_ready,
        output ihit, iload, dhit, dload, ramREN, ramWEN, ramaddr, ramstore
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, datomic, daddr, dstore, ramload, ram_ready,
        input  ihit, iload, dhit, dload, ramREN, ramWEN, ramaddr, ramstore
    );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter: data-priority with fetch starvation guard and LL/SC link register.
// Optional performance counters are built when MEM_ARBITER_PERF_EN is defined.
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int ADDR_W       = 32
) (
    input  logic          CLK,
    input  logic          RST,
    mem_arbiter_if.slave  bus
`ifdef MEM_ARBITER_PERF_EN
    ,
    output logic [31:0]   perf_igrants,
    output logic [31:0]   perf_dgrants,
    output logic [31:0]   perf_wait
`endif
);
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IGRANT = 2'd1,
        DGRANT = 2'd2,
        SCFAIL = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
    logic              link_valid_q, link_valid_d;
    logic [ADDR_W-1:0] link_addr_q, link_addr_d;

    logic              data_req_s;
    logic              link_hit_s;
    logic [CNT_W-1:0]  starve_next_s;
    logic              ihit_s, dhit_s, ram_ren_s, ram_wen_s;
    logic [ADDR_W-1:0] iload_s, dload_s, ram_addr_s, ram_store_s;

    // Request decode and the starvation count a completed data grant would leave behind.
    always_comb begin
        data_req_s = bus.dREN | bus.dWEN;
        link_hit_s = link_valid_q && (link_addr_q == bus.daddr);
        if (!bus.iREN) begin
            starve_next_s = '0;
        end else if (starve_cnt_q == LIMIT_C) begin
            starve_next_s = starve_cnt_q;
        end else begin
            starve_next_s = starve_cnt_q + CNT_W'(1);
        end
    end

    // Next-state, link register and bus output decode.
    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        link_valid_d = link_valid_q;
        link_addr_d  = link_addr_q;
        ihit_s       = 1'b0;
        iload_s      = '0;
        dhit_s       = 1'b0;
        dload_s      = '0;
        ram_ren_s    = 1'b0;
        ram_wen_s    = 1'b0;
        ram_addr_s   = '0;
        ram_store_s  = '0;
        case (state_q)
            IDLE: begin
                if (data_req_s && ((starve_cnt_q < LIMIT_C) || !bus.iREN)) begin
                    // A store-conditional that has already lost its link never touches RAM.
                    if (bus.dWEN && bus.datomic && !link_hit_s) begin
                        state_d = SCFAIL;
                    end else begin
                        state_d = DGRANT;
                    end
                end else if (bus.iREN) begin
                    state_d = IGRANT;
                end else begin
                    state_d = IDLE;
                end
            end
            IGRANT: begin
                ram_ren_s  = 1'b1;
                ram_addr_s = bus.iaddr;
                if (bus.ram_ready) begin
                    ihit_s       = 1'b1;
                    iload_s      = bus.ramload;
                    starve_cnt_d = '0;
                    state_d      = IDLE;
                end else begin
                    state_d = IGRANT;
                end
            end
            DGRANT: begin
                ram_addr_s = bus.daddr;
                if (bus.dWEN) begin
                    ram_wen_s   = 1'b1;
                    ram_store_s = bus.dstore;
                end else begin
                    ram_ren_s = 1'b1;
                end
                if (bus.ram_ready) begin
                    dhit_s       = 1'b1;
                    starve_cnt_d = starve_next_s;
                    state_d      = IDLE;
                    if (bus.dWEN) begin
                        if (bus.datomic) begin
                            dload_s      = {{(ADDR_W-1){1'b0}}, 1'b1};
                            link_valid_d = 1'b0;
                        end else if (link_addr_q == bus.daddr) begin
                            link_valid_d = 1'b0;
                        end else begin
                            link_valid_d = link_valid_q;
                        end
                    end else begin
                        dload_s = bus.ramload;
                        if (bus.datomic) begin
                            link_valid_d = 1'b1;
                            link_addr_d  = bus.daddr;
                        end else begin
                            link_valid_d = link_valid_q;
                        end
                    end
                end else begin
                    state_d = DGRANT;
                end
            end
            SCFAIL: begin
                dhit_s       = 1'b1;
                starve_cnt_d = starve_next_s;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // An access caught by reset is abandoned: no completion is reported.
        if (RST) begin
            ihit_s  = 1'b0;
            iload_s = '0;
            dhit_s  = 1'b0;
            dload_s = '0;
        end else begin
            ihit_s = ihit_s;
        end
    end

    // Arbiter state, starvation counter and link register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= IDLE;
            starve_cnt_q <= '0;
            link_valid_q <= 1'b0;
            link_addr_q  <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            link_valid_q <= link_valid_d;
            link_addr_q  <= link_addr_d;
        end
    end

    assign bus.ihit     = ihit_s;
    assign bus.iload    = iload_s;
    assign bus.dhit     = dhit_s;
    assign bus.dload    = dload_s;
    assign bus.ramREN   = ram_ren_s;
    assign bus.ramWEN   = ram_wen_s;
    assign bus.ramaddr  = ram_addr_s;
    assign bus.ramstore = ram_store_s;

`ifdef MEM_ARBITER_PERF_EN
    logic [31:0] perf_igrants_q, perf_igrants_d;
    logic [31:0] perf_dgrants_q, perf_dgrants_d;
    logic [31:0] perf_wait_q, perf_wait_d;

    // Grant and wait-state event counters, wrapping modulo 2^32.
    always_comb begin
        perf_igrants_d = perf_igrants_q + (ihit_s ? 32'd1 : 32'd0);
        perf_dgrants_d = perf_dgrants_q + (dhit_s ? 32'd1 : 32'd0);
        if (((state_q == IGRANT) || (state_q == DGRANT)) && !bus.ram_ready) begin
            perf_wait_d = perf_wait_q + 32'd1;
        end else begin
            perf_wait_d = perf_wait_q;
        end
    end

    // Performance counter registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            perf_igrants_q <= 32'd0;
            perf_dgrants_q <= 32'd0;
            perf_wait_q    <= 32'd0;
        end else begin
            perf_igrants_q <= perf_igrants_d;
            perf_dgrants_q <= perf_dgrants_d;
            perf_wait_q    <= perf_wait_d;
        end
    end

    assign perf_igrants = perf_igrants_q;
    assign perf_dgrants = perf_dgrants_q;
    assign perf_wait    = perf_wait_q;
`endif
endmodule
